// File: rtl/vpifo_task_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : vpifo_pkg
// Brief  : Shared types and default sizing for the virtual-PIFO task queue.
// Rev    : 1.0  initial release
// ============================================================================
package vpifo_pkg;

    localparam int VP_PTW      = 16;
    localparam int VP_TREE_NUM = 4;
    localparam int VP_TREE_CAP = 72;
    localparam int VP_TIDW     = $clog2(VP_TREE_NUM);

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } vpifo_op_e;

    typedef struct packed {
        vpifo_op_e             op;
        logic [VP_TIDW-1:0]    tree;
        logic [VP_PTW-1:0]     data;
    } vpifo_req_t;

endpackage
`default_nettype wire

// File: rtl/vpifo_task_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module : vpifo_sync_fifo
// Brief  : Synchronous show-ahead FIFO, valid/ready write side, wrap-bit pointers.
// Rev    : 1.0  initial release
// ============================================================================
module vpifo_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_rd_ready
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_full;
    logic             w_empty;

    assign w_empty    = (r_wp == r_rp);
    assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_wr_ready = !w_full;
    assign o_rd_valid = !w_empty;
    assign o_rd_data  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_wr_valid && !w_full) begin
                r_mem[r_wp[AW-1:0]] <= i_wr_data;
                r_wp                <= r_wp + 1'b1;
            end
            if (i_rd_ready && !w_empty) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vpifo_task_queue.sv
`default_nettype none
// ============================================================================
// Module : vpifo_task_queue
// Brief  : Per-port request FIFOs, per-tree arbiter and occupancy tracking in
//          front of a virtualised PIFO.
// Rev    : 1.0  initial release
// ============================================================================
module vpifo_task_queue
    import vpifo_pkg::*;
#(
    parameter int PTW      = VP_PTW,
    parameter int NPORT    = 2,
    parameter int TREE_NUM = VP_TREE_NUM,
    parameter int TREE_CAP = VP_TREE_CAP,
    parameter int QDEPTH   = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NPORT-1:0]                   i_req_valid,
    output logic [NPORT-1:0]                   o_req_ready,
    input  logic [NPORT-1:0]                   i_req_op,
    input  logic [NPORT*$clog2(TREE_NUM)-1:0]  i_req_tree,
    input  logic [NPORT*PTW-1:0]               i_req_data,
    input  logic [NPORT-1:0]                   i_pifo_full,
    output logic [NPORT-1:0]                   o_push,
    output logic [NPORT-1:0]                   o_pop,
    output logic [NPORT*$clog2(TREE_NUM)-1:0]  o_tree_id,
    output logic [NPORT*PTW-1:0]               o_push_data,
    output logic [NPORT-1:0]                   o_err_pop_empty,
    output logic [TREE_NUM*$clog2(TREE_CAP+1)-1:0] o_tree_occ
);
    localparam int TIDW = $clog2(TREE_NUM);
    localparam int OCW  = $clog2(TREE_CAP + 1);
    localparam int REQW = 1 + TIDW + PTW;
    localparam logic [OCW-1:0] c_cap = OCW'(TREE_CAP);

    logic [NPORT-1:0] w_fifo_ready;
    logic [NPORT-1:0] w_fifo_valid;
    logic [REQW-1:0]  w_head      [NPORT];
    vpifo_op_e        w_head_op   [NPORT];
    logic [TIDW-1:0]  w_head_tree [NPORT];
    logic [PTW-1:0]   w_head_data [NPORT];

    logic [TREE_NUM-1:0] w_claim;
    logic [NPORT-1:0]    w_deq;
    logic [NPORT-1:0]    w_iss_push;
    logic [NPORT-1:0]    w_iss_pop;
    logic [NPORT-1:0]    w_iss_err;
    logic [OCW-1:0]      w_occ_nxt [TREE_NUM];

    logic [OCW-1:0]           r_occ [TREE_NUM];
    logic [NPORT-1:0]         r_push;
    logic [NPORT-1:0]         r_pop;
    logic [NPORT-1:0]         r_err;
    logic [NPORT*TIDW-1:0]    r_tree_id;
    logic [NPORT*PTW-1:0]     r_push_data;

    generate
        for (genvar p = 0; p < NPORT; p++) begin : g_port
            vpifo_sync_fifo #(
                .WIDTH (REQW),
                .DEPTH (QDEPTH)
            ) u_fifo (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_wr_valid (i_req_valid[p]),
                .o_wr_ready (w_fifo_ready[p]),
                .i_wr_data  ({i_req_op[p], i_req_tree[p*TIDW +: TIDW], i_req_data[p*PTW +: PTW]}),
                .o_rd_valid (w_fifo_valid[p]),
                .o_rd_data  (w_head[p]),
                .i_rd_ready (w_deq[p])
            );
            assign w_head_op[p]   = vpifo_op_e'(w_head[p][REQW-1]);
            assign w_head_tree[p] = w_head[p][PTW +: TIDW];
            assign w_head_data[p] = w_head[p][PTW-1:0];
        end

        for (genvar t = 0; t < TREE_NUM; t++) begin : g_occ
            assign o_tree_occ[t*OCW +: OCW] = r_occ[t];
        end
    endgenerate

    assign o_req_ready     = w_fifo_ready & {NPORT{!i_rst}};
    assign o_push          = r_push;
    assign o_pop           = r_pop;
    assign o_err_pop_empty = r_err;
    assign o_tree_id       = r_tree_id;
    assign o_push_data     = r_push_data;

    // Fixed-priority walk: a port that wins a tree marks it claimed so higher
    // ports see it busy. Stalled pushes to a full tree do not claim it.
    always_comb begin
        w_claim    = '0;
        w_deq      = '0;
        w_iss_push = '0;
        w_iss_pop  = '0;
        w_iss_err  = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (w_fifo_valid[p] && !i_pifo_full[p] && !w_claim[w_head_tree[p]]) begin
                if (w_head_op[p] == OP_POP) begin
                    w_claim[w_head_tree[p]] = 1'b1;
                    w_deq[p]                = 1'b1;
                    if (r_occ[w_head_tree[p]] == '0) begin
                        w_iss_err[p] = 1'b1;
                    end else begin
                        w_iss_pop[p] = 1'b1;
                    end
                end else if (r_occ[w_head_tree[p]] < c_cap) begin
                    w_claim[w_head_tree[p]] = 1'b1;
                    w_deq[p]                = 1'b1;
                    w_iss_push[p]           = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_occ_nxt = r_occ;
        for (int p = 0; p < NPORT; p++) begin
            if (w_iss_push[p]) begin
                w_occ_nxt[w_head_tree[p]] = w_occ_nxt[w_head_tree[p]] + OCW'(1);
            end else if (w_iss_pop[p]) begin
                w_occ_nxt[w_head_tree[p]] = w_occ_nxt[w_head_tree[p]] - OCW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ       <= '{default: '0};
            r_push      <= '0;
            r_pop       <= '0;
            r_err       <= '0;
            r_tree_id   <= '0;
            r_push_data <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_push <= w_iss_push;
            r_pop  <= w_iss_pop;
            r_err  <= w_iss_err;
            for (int p = 0; p < NPORT; p++) begin
                if (w_iss_push[p] || w_iss_pop[p]) begin
                    r_tree_id[p*TIDW +: TIDW] <= w_head_tree[p];
                end
                if (w_iss_push[p]) begin
                    r_push_data[p*PTW +: PTW] <= w_head_data[p];
                end
            end
        end
    end

endmodule
`default_nettype wire
